// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding word
// reads to instruction memory and queues returned words for decode.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no request outstanding (queue full, or just redirected)
// S_WAIT  | request outstanding at fetch_pc, returned word is kept
// S_FLUSH | stale request outstanding at stale_pc, returned word dropped
module instr_fetch_unit #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_W-1:0]          imem_rdata,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       ins_valid,
  output logic [DATA_W-1:0]          ins,
  output logic [ADDR_W-1:0]          ins_pc,
  input  logic                       ins_ready,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   stale_pc_q, stale_pc_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   head_data_q, head_data_d;
  logic [ADDR_W-1:0]   head_pc_q, head_pc_d;
  logic [DATA_W-1:0]   mem_data [DEPTH];
  logic [ADDR_W-1:0]   mem_pc [DEPTH];

  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [PTR_W-1:0]    rd_next_idx;

  assign pop         = (count_q != '0) && ins_ready;
  assign push        = (state_q == S_WAIT) && imem_ack && !redirect;
  assign cnt_nxt     = count_q + CNT_W'(push) - CNT_W'(pop);
  assign rd_next_idx = rd_ptr_q + PTR_W'(1);

  // A flushed request keeps its original address on the bus until it is acked.
  assign imem_req  = (state_q != S_IDLE);
  assign imem_addr = (state_q == S_FLUSH) ? stale_pc_q : fetch_pc_q;
  assign ins_valid = (count_q != '0);
  assign ins       = head_data_q;
  assign ins_pc    = head_pc_q;
  assign occupancy = count_q;

  // Fetch FSM next-state and fetch PC update.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stale_pc_d = stale_pc_q;
    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
        end else if (cnt_nxt < DEPTH_C) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          fetch_pc_d = redirect_pc;
          if (imem_ack) begin
            state_d = S_IDLE;
          end else begin
            state_d    = S_FLUSH;
            stale_pc_d = fetch_pc_q;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          if (cnt_nxt >= DEPTH_C) state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (redirect) fetch_pc_d = redirect_pc;
        if (imem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Queue pointers, count and the registered head copy seen by decode.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      count_d  = cnt_nxt;
      if (pop && (count_q > CNT_W'(1))) begin
        head_data_d = mem_data[rd_next_idx];
        head_pc_d   = mem_pc[rd_next_idx];
      end else if (push && (pop || (count_q == '0))) begin
        head_data_d = imem_rdata;
        head_pc_d   = fetch_pc_q;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fetch_pc_q  <= RESET_PC;
      stale_pc_q  <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      head_data_q <= '0;
      head_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      stale_pc_q  <= stale_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
    end
  end

  // Queue storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected
// {pc, word} pairs consumed by a monitor on every accepted instruction.
module tb_instr_fetch_unit;

  localparam logic [15:0] KEY = 16'hA5C3;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ins_valid;
  logic [15:0] ins;
  logic [15:0] ins_pc;
  logic        ins_ready;
  logic [2:0]  occupancy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_e;

  instr_fetch_unit #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc),
    .ins_ready(ins_ready), .occupancy(occupancy)
  );

  // Memory model: every word is its address scrambled by a constant.
  assign imem_rdata = imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic exp_push(input logic [15:0] pc);
    sb.push_back({pc, pc ^ KEY});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h0000);
    chk("rst_ins", 32'(ins), 32'd0);
    chk("rst_ins_pc", 32'(ins_pc), 32'd0);
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every accepted head must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst && ins_valid && ins_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual pc=%h ins=%h expected none", ins_pc, ins);
      end else begin
        exp_e = sb.pop_front();
        if ({ins_pc, ins} !== exp_e) begin
          errors++;
          $display("FAIL pop_data actual=%h expected=%h", {ins_pc, ins}, exp_e);
        end
      end
    end
  end

  initial begin
    rst         = 1'b0;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    ins_ready   = 1'b0;
    #2;

    // Streaming: zero-wait memory, decode always ready.
    do_reset();
    imem_ack = 1'b1; ins_ready = 1'b1;
    for (int p = 0; p < 6; p++) exp_push(16'(p));
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("stream_addr%0d", k), 32'(imem_addr), 32'(k - 1));
      if (k >= 2) begin
        chk($sformatf("stream_pc%0d", k), 32'(ins_pc), 32'(k - 2));
        chk($sformatf("stream_occ%0d", k), 32'(occupancy), 32'd1);
      end
    end
    ins_ready = 1'b0; imem_ack = 1'b0;
    chk("stream_drain", 32'(sb.size()), 32'd0);

    // Fill to capacity with decode stalled, then release one entry.
    do_reset();
    imem_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("fill_addr%0d", k), 32'(imem_addr), 32'(k - 1));
    end
    tick();
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_occ", 32'(occupancy), 32'd4);
    tick();
    chk("full_req_hold", 32'(imem_req), 32'd0);
    exp_push(16'h0000);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0; imem_ack = 1'b0;
    chk("reissue_req", 32'(imem_req), 32'd1);
    chk("reissue_addr", 32'(imem_addr), 32'd4);
    chk("reissue_occ", 32'(occupancy), 32'd3);
    chk("reissue_head", 32'(ins_pc), 32'd1);
    chk("fill_drain", 32'(sb.size()), 32'd0);

    // Three wait states before the ack.
    do_reset();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("wait_addr%0d", k), 32'(imem_addr), 32'd0);
      chk($sformatf("wait_req%0d", k), 32'(imem_req), 32'd1);
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    chk("wait_occ", 32'(occupancy), 32'd1);
    chk("wait_ins", 32'(ins), 32'(16'h0000 ^ KEY));
    chk("wait_next_addr", 32'(imem_addr), 32'd1);
    exp_push(16'h0000);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    chk("empty_valid", 32'(ins_valid), 32'd0);
    chk("empty_hold_pc", 32'(ins_pc), 32'd0);
    chk("wait_drain", 32'(sb.size()), 32'd0);

    // Redirect while a request is pending with two entries queued.
    do_reset();
    imem_ack = 1'b1;
    tick(); tick(); tick();
    imem_ack = 1'b0;
    tick();
    chk("pre_redir_occ", 32'(occupancy), 32'd2);
    chk("pre_redir_addr", 32'(imem_addr), 32'd2);
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    chk("redir_occ", 32'(occupancy), 32'd0);
    chk("redir_valid", 32'(ins_valid), 32'd0);
    chk("flush_req", 32'(imem_req), 32'd1);
    chk("flush_addr", 32'(imem_addr), 32'd2);
    imem_ack = 1'b1;
    tick();
    chk("stale_req", 32'(imem_req), 32'd0);
    chk("stale_occ", 32'(occupancy), 32'd0);
    tick();
    chk("redir_addr", 32'(imem_addr), 32'h0040);
    tick();
    chk("redir_ins_pc", 32'(ins_pc), 32'h0040);
    chk("redir_ins", 32'(ins), 32'(16'h0040 ^ KEY));
    exp_push(16'h0040);
    ins_ready = 1'b1; imem_ack = 1'b0;
    tick();
    ins_ready = 1'b0;
    chk("redir_drain", 32'(sb.size()), 32'd0);

    // Redirect, ack and pop in the same cycle.
    do_reset();
    imem_ack = 1'b1;
    tick(); tick(); tick();
    exp_push(16'h0000);
    redirect = 1'b1; redirect_pc = 16'h0040; ins_ready = 1'b1;
    tick();
    redirect = 1'b0; ins_ready = 1'b0;
    chk("rap_occ", 32'(occupancy), 32'd0);
    chk("rap_req", 32'(imem_req), 32'd0);
    tick();
    chk("rap_addr", 32'(imem_addr), 32'h0040);
    chk("rap_req2", 32'(imem_req), 32'd1);
    tick();
    chk("rap_ins_pc", 32'(ins_pc), 32'h0040);
    chk("rap_occ2", 32'(occupancy), 32'd1);
    exp_push(16'h0040);
    ins_ready = 1'b1; imem_ack = 1'b0;
    tick();
    ins_ready = 1'b0;
    chk("rap_drain", 32'(sb.size()), 32'd0);

    // Reset mid-request with two entries queued; ack during IDLE ignored.
    do_reset();
    imem_ack = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    do_reset();
    tick();
    chk("post_rst_occ", 32'(occupancy), 32'd0);
    chk("post_rst_addr", 32'(imem_addr), 32'h0000);
    chk("post_rst_req", 32'(imem_req), 32'd1);
    tick();
    chk("post_rst_ins_pc", 32'(ins_pc), 32'h0000);
    chk("post_rst_occ2", 32'(occupancy), 32'd1);
    exp_push(16'h0000);
    ins_ready = 1'b1; imem_ack = 1'b0;
    tick();
    ins_ready = 1'b0;
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
